// File: rtl/axi_gp0_if.sv
// rtl/axi_gp0_if.sv - AXI3 GP0 channel bundle between PS7 master and register slave
interface axi_gp0_if;
   logic [11:0] ar_id;
   logic [31:0] ar_addr;
   logic [3:0]  ar_len;
   logic [1:0]  ar_burst;
   logic        ar_valid;
   logic        ar_ready;

   logic [11:0] r_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        r_valid;
   logic        r_ready;

   logic [11:0] aw_id;
   logic [31:0] aw_addr;
   logic [3:0]  aw_len;
   logic [1:0]  aw_burst;
   logic        aw_valid;
   logic        aw_ready;

   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last;
   logic        w_valid;
   logic        w_ready;

   logic [11:0] b_id;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready;

   modport slave (
      input  ar_id, ar_addr, ar_len, ar_burst, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_valid,
      input  r_ready,
      input  aw_id, aw_addr, aw_len, aw_burst, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_valid,
      output w_ready,
      output b_id, b_resp, b_valid,
      input  b_ready
   );

   modport master (
      output ar_id, ar_addr, ar_len, ar_burst, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_valid,
      output r_ready,
      output aw_id, aw_addr, aw_len, aw_burst, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_valid,
      output b_ready
   );
endinterface

// File: rtl/axi_gp0_regs.sv
// rtl/axi_gp0_regs.sv - AXI3 slave serializing GP0 bursts onto a small register bank
// One transaction in flight; read/write address channels arbitrated by a toggling priority.
module axi_gp0_regs #(
   parameter int NREGS = 4,
   parameter int LED_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   axi_gp0_if.slave         bus,
   output logic [LED_W-1:0] led
);
   localparam int          IW        = $clog2(NREGS);
   localparam logic [9:0]  NREGS_OFF = 10'(NREGS);

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;     // 0: read wins a tie, 1: write wins
   logic        err_q, err_d;
   logic [11:0] id_q, id_d;
   logic [9:0]  off_q, off_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  beat_q, beat_d;
   logic [1:0]  burst_q, burst_d;
   logic [31:0] regs_q [NREGS];
   logic [31:0] regs_d [NREGS];

   logic          in_range;
   logic          is_last;
   logic [9:0]    off_step;
   logic [IW-1:0] idx;
   logic          unused_addr_bits;

   assign in_range = off_q < NREGS_OFF;
   assign is_last  = beat_q == len_q;
   assign idx      = off_q[IW-1:0];
   // WRAP is stepped like INCR; FIXED and the reserved encoding hold the offset
   assign off_step = (burst_q == 2'b01 || burst_q == 2'b10) ? off_q + 10'd1 : off_q;

   assign unused_addr_bits = ^{bus.ar_addr[31:12], bus.ar_addr[1:0],
                               bus.aw_addr[31:12], bus.aw_addr[1:0]};

   assign bus.ar_ready = ~rst & (state_q == IDLE) & bus.ar_valid & (~bus.aw_valid | ~prio_q);
   assign bus.aw_ready = ~rst & (state_q == IDLE) & bus.aw_valid & (~bus.ar_valid | prio_q);

   assign bus.r_valid = state_q == RD;
   assign bus.r_id    = (state_q == RD) ? id_q : 12'd0;
   assign bus.r_data  = (state_q == RD && in_range) ? regs_q[idx] : 32'd0;
   assign bus.r_resp  = (state_q == RD && !in_range) ? 2'b10 : 2'b00;
   assign bus.r_last  = (state_q == RD) && is_last;

   assign bus.w_ready = state_q == WR;

   assign bus.b_valid = state_q == WRESP;
   assign bus.b_id    = (state_q == WRESP) ? id_q : 12'd0;
   assign bus.b_resp  = (state_q == WRESP && err_q) ? 2'b10 : 2'b00;

   assign led = regs_q[0][LED_W-1:0];

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      err_d   = err_q;
      id_d    = id_q;
      off_d   = off_q;
      len_d   = len_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      regs_d  = regs_q;
      case (state_q)
         IDLE: begin
            if (bus.ar_valid && bus.aw_valid) prio_d = ~prio_q;
            if (bus.ar_ready) begin
               id_d    = bus.ar_id;
               off_d   = bus.ar_addr[11:2];
               len_d   = bus.ar_len;
               burst_d = bus.ar_burst;
               beat_d  = 4'd0;
               state_d = RD;
            end else if (bus.aw_ready) begin
               id_d    = bus.aw_id;
               off_d   = bus.aw_addr[11:2];
               len_d   = bus.aw_len;
               burst_d = bus.aw_burst;
               beat_d  = 4'd0;
               state_d = WR;
            end
         end
         RD: begin
            if (bus.r_ready) begin
               if (is_last) begin
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + 4'd1;
                  off_d  = off_step;
               end
            end
         end
         WR: begin
            if (bus.w_valid) begin
               if (in_range) begin
                  for (int i = 0; i < 4; i++) begin
                     if (bus.w_strb[i]) regs_d[idx][8*i +: 8] = bus.w_data[8*i +: 8];
                  end
               end else begin
                  err_d = 1'b1;
               end
               // beat count ends the burst; a misplaced w_last only flags the error
               if (bus.w_last != is_last) err_d = 1'b1;
               if (is_last) begin
                  state_d = WRESP;
               end else begin
                  beat_d = beat_q + 4'd1;
                  off_d  = off_step;
               end
            end
         end
         WRESP: begin
            if (bus.b_ready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         err_q   <= 1'b0;
         id_q    <= 12'd0;
         off_q   <= 10'd0;
         len_q   <= 4'd0;
         beat_q  <= 4'd0;
         burst_q <= 2'b00;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == 0) ? 32'h5555_5555 : 32'd0;
         end
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         err_q   <= err_d;
         id_q    <= id_d;
         off_q   <= off_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         regs_q  <= regs_d;
      end
   end
endmodule

// File: tb/tb_axi_gp0_regs.sv
// tb/tb_axi_gp0_regs.sv - directed vector bench for axi_gp0_regs
module tb_axi_gp0_regs;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] led;

   axi_gp0_if bus();

   axi_gp0_regs #(.NREGS(4), .LED_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .led (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [31:0] rdata;
      logic [1:0]  rresp;
   } vec_t;

   vec_t        vecs [7];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [11:0] rd_id;
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [1:0]  b_resp_got;
   logic [11:0] b_id_got;
   logic [3:0]  led_got;
   logic [31:0] exp4 [4];
   int          grant [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic ar_go(input logic [11:0] id, input logic [31:0] addr,
                        input logic [3:0] len, input logic [1:0] burst);
      int n = 0;
      @(negedge clk);
      bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_burst = burst;
      bus.ar_valid = 1'b1;
      #1;
      while (!bus.ar_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("ar_accept", 32'(bus.ar_ready), 32'd1);
      @(posedge clk); #1;
      bus.ar_valid = 1'b0;
   endtask

   task automatic rd(input logic [11:0] id, input logic [31:0] addr,
                     input logic [3:0] len, input logic [1:0] burst);
      ar_go(id, addr, len, burst);
      bus.r_ready = 1'b1;
      @(negedge clk); #1;
      check("r_valid_lat", 32'(bus.r_valid), 32'd1);
      rd_id = bus.r_id;
      for (int k = 0; k <= int'(len); k++) begin
         if (k > 0) begin
            @(negedge clk); #1;
         end
         rd_data[k] = bus.r_data;
         rd_resp[k] = bus.r_resp;
         rd_last[k] = bus.r_last;
      end
      @(negedge clk); #1;
      check("r_valid_end", 32'(bus.r_valid), 32'd0);
      bus.r_ready = 1'b0;
   endtask

   task automatic wr(input logic [11:0] id, input logic [31:0] addr,
                     input logic [3:0] len, input logic [1:0] burst, input int last_at);
      int n = 0;
      @(negedge clk);
      bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_burst = burst;
      bus.aw_valid = 1'b1;
      #1;
      while (!bus.aw_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("aw_accept", 32'(bus.aw_ready), 32'd1);
      @(posedge clk); #1;
      bus.aw_valid = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         @(negedge clk);
         bus.w_data = wd[k]; bus.w_strb = ws[k]; bus.w_last = (k == last_at); bus.w_valid = 1'b1;
         #1;
         check("w_ready", 32'(bus.w_ready), 32'd1);
      end
      @(negedge clk);
      bus.w_valid = 1'b0; bus.w_last = 1'b0;
      #1;
      check("b_valid_lat", 32'(bus.b_valid), 32'd1);
      b_resp_got = bus.b_resp;
      b_id_got   = bus.b_id;
      led_got    = led;
      bus.b_ready = 1'b1;
      @(negedge clk);
      bus.b_ready = 1'b0;
      #1;
      check("b_valid_end", 32'(bus.b_valid), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int cyc;
      int g;

      vecs[0] = '{32'h0000_0004, 32'h1122_3344, 4'hF,    2'b00, 32'h1122_3344, 2'b00};
      vecs[1] = '{32'h0000_0008, 32'hAABB_CCDD, 4'b1010, 2'b00, 32'hAA00_CC00, 2'b00};
      vecs[2] = '{32'h0000_000C, 32'hDEAD_BEEF, 4'b1100, 2'b00, 32'hDEAD_0000, 2'b00};
      vecs[3] = '{32'h0000_0010, 32'h0000_0001, 4'hF,    2'b10, 32'h0000_0000, 2'b10};
      vecs[4] = '{32'h1000_0004, 32'h0000_0055, 4'b0001, 2'b00, 32'h1122_3355, 2'b00};
      vecs[5] = '{32'h0000_0FFC, 32'h1234_5678, 4'hF,    2'b10, 32'h0000_0000, 2'b10};
      vecs[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'h0,    2'b00, 32'h5555_550A, 2'b00};

      bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_burst = 2'b01; bus.ar_valid = 1'b1;
      bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_burst = 2'b01; bus.aw_valid = 1'b0;
      bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
      bus.r_ready = 1'b0; bus.b_ready = 1'b0;
      rst = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      check("ar_ready_in_rst", 32'(bus.ar_ready), 32'd0);
      bus.ar_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk); #1;
      check("rst_ctrl", 32'({bus.r_valid, bus.b_valid, bus.ar_ready, bus.aw_ready,
                             bus.w_ready, bus.r_last, bus.r_resp, bus.b_resp}), 32'd0);
      check("rst_data", bus.r_data, 32'd0);
      check("rst_ids", 32'({bus.r_id, bus.b_id}), 32'd0);
      check("rst_led", 32'(led), 32'h5);

      rd(12'h123, 32'h0, 4'd0, 2'b01);
      check("rd0_data", rd_data[0], 32'h5555_5555);
      check("rd0_resp", 32'(rd_resp[0]), 32'd0);
      check("rd0_last", 32'(rd_last[0]), 32'd1);
      check("rd0_id", 32'(rd_id), 32'h123);

      wd[0] = 32'h0000_000A; ws[0] = 4'b0001;
      wr(12'h7, 32'h0, 4'd0, 2'b01, 0);
      check("wr0_bresp", 32'(b_resp_got), 32'd0);
      check("wr0_bid", 32'(b_id_got), 32'h7);
      check("wr0_led", 32'(led_got), 32'hA);
      rd(12'h1, 32'h0, 4'd0, 2'b01);
      check("wr0_readback", rd_data[0], 32'h5555_550A);

      for (int i = 0; i < 7; i++) begin
         wd[0] = vecs[i].data; ws[0] = vecs[i].strb;
         wr(12'(i), vecs[i].addr, 4'd0, 2'b01, 0);
         check($sformatf("vec%0d_bresp", i), 32'(b_resp_got), 32'(vecs[i].bresp));
         check($sformatf("vec%0d_bid", i), 32'(b_id_got), 32'(i));
         rd(12'(i + 32), vecs[i].addr, 4'd0, 2'b01);
         check($sformatf("vec%0d_rdata", i), rd_data[0], vecs[i].rdata);
         check($sformatf("vec%0d_rresp", i), 32'(rd_resp[0]), 32'(vecs[i].rresp));
         check($sformatf("vec%0d_rlast", i), 32'(rd_last[0]), 32'd1);
      end

      exp4[0] = 32'h5555_550A; exp4[1] = 32'h1122_3355;
      exp4[2] = 32'hAA00_CC00; exp4[3] = 32'hDEAD_0000;
      ar_go(12'h44, 32'h0, 4'd3, 2'b01);
      b = 0; cyc = 0;
      while (b < 4 && cyc < 20) begin
         @(negedge clk);
         bus.r_ready = (cyc % 2 == 0);
         #1;
         check($sformatf("stall_valid_c%0d", cyc), 32'(bus.r_valid), 32'd1);
         check($sformatf("stall_data_c%0d", cyc), bus.r_data, exp4[b]);
         check($sformatf("stall_last_c%0d", cyc), 32'(bus.r_last), 32'(b == 3));
         if (bus.r_ready) b++;
         cyc++;
      end
      check("stall_beats", 32'(b), 32'd4);
      @(negedge clk);
      bus.r_ready = 1'b0;
      #1;
      check("stall_end", 32'(bus.r_valid), 32'd0);

      for (int k = 0; k < 6; k++) begin
         wd[k] = 32'h100 + 32'(k); ws[k] = 4'hF;
      end
      wr(12'h9, 32'h8, 4'd5, 2'b01, 5);
      check("incr_oor_bresp", 32'(b_resp_got), 32'h2);
      rd(12'h9, 32'h8, 4'd3, 2'b01);
      check("incr_r2", rd_data[0], 32'h100);
      check("incr_r3", rd_data[1], 32'h101);
      check("incr_r4", rd_data[2], 32'h0);
      check("incr_resp", 32'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 32'b00_00_10_10);
      check("incr_last", 32'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 32'b0001);

      wd[0] = 32'hA1; wd[1] = 32'hB2; ws[0] = 4'hF; ws[1] = 4'hF;
      wr(12'hA, 32'h4, 4'd1, 2'b00, 1);
      check("fixed_bresp", 32'(b_resp_got), 32'd0);
      rd(12'hA, 32'h4, 4'd0, 2'b01);
      check("fixed_r1", rd_data[0], 32'hB2);

      wd[0] = 32'hC; wd[1] = 32'hD;
      wr(12'hB, 32'h0, 4'd1, 2'b01, 0);
      check("wlast_bresp", 32'(b_resp_got), 32'h2);
      check("wlast_led", 32'(led_got), 32'hC);
      rd(12'hB, 32'h0, 4'd1, 2'b01);
      check("wlast_r0", rd_data[0], 32'hC);
      check("wlast_r1", rd_data[1], 32'hD);

      rd(12'hC, 32'hFFC, 4'd1, 2'b01);
      check("wrap_resp", 32'({rd_resp[0], rd_resp[1]}), 32'b10_00);
      check("wrap_data", rd_data[1], 32'hC);

      rd(12'hD, 32'h4, 4'd1, 2'b11);
      check("rsvd_data", {rd_data[0][15:0], rd_data[1][15:0]}, 32'h000D_000D);

      bus.r_ready = 1'b1; bus.b_ready = 1'b1;
      bus.w_valid = 1'b1; bus.w_last = 1'b1; bus.w_data = 32'hEE; bus.w_strb = 4'hF;
      bus.ar_addr = 32'h0; bus.ar_len = 4'd0; bus.ar_burst = 2'b01; bus.ar_id = 12'h1;
      bus.aw_addr = 32'h10; bus.aw_len = 4'd0; bus.aw_burst = 2'b01; bus.aw_id = 12'h2;
      @(negedge clk);
      bus.ar_valid = 1'b1; bus.aw_valid = 1'b1;
      g = 0; cyc = 0;
      while (g < 4 && cyc < 60) begin
         #1;
         check($sformatf("ready_excl_c%0d", cyc), 32'(bus.ar_ready & bus.aw_ready), 32'd0);
         if (bus.ar_ready) begin
            grant[g] = 0; g++;
         end else if (bus.aw_ready) begin
            grant[g] = 1; g++;
         end
         if (g == 4) begin
            @(posedge clk); #1;
            bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      check("arb_count", 32'(g), 32'd4);
      check("arb_order", {grant[0][7:0], grant[1][7:0], grant[2][7:0], grant[3][7:0]}, 32'h00010001);
      repeat (4) @(negedge clk);
      bus.r_ready = 1'b0; bus.b_ready = 1'b0; bus.w_valid = 1'b0; bus.w_last = 1'b0;

      ar_go(12'h55, 32'h0, 4'd3, 2'b01);
      bus.r_ready = 1'b1;
      @(negedge clk); #1;
      check("rstmid_b1", bus.r_data, 32'hC);
      @(negedge clk); #1;
      check("rstmid_b2_valid", 32'(bus.r_valid), 32'd1);
      check("rstmid_b2", bus.r_data, 32'hD);
      rst = 1'b1;
      @(negedge clk); #1;
      check("rstmid_rvalid", 32'(bus.r_valid), 32'd0);
      rst = 1'b0;
      bus.r_ready = 1'b0;
      check("rstmid_led", 32'(led), 32'h5);
      rd(12'h66, 32'h0, 4'd1, 2'b01);
      check("rstmid_r0", rd_data[0], 32'h5555_5555);
      check("rstmid_r1", rd_data[1], 32'h0);
      check("rstmid_last", 32'({rd_last[0], rd_last[1]}), 32'b01);
      check("rstmid_id", 32'(rd_id), 32'h66);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_gp0_regs.md
# axi_gp0_regs

AXI3 slave controller that sits on the PS7 MAXIGP0 port and serializes master read and write transactions onto a small 32-bit register bank. It arbitrates between the read and write channels and sequences bursts of up to 16 beats. It generates RID/BID echo, RLAST and OKAY/SLVERR responses. Register 0 drives the board LEDs.

## Interface
- NREGS, 4: number of 32-bit registers, power of 2, 2..256
- LED_W, 4: LED bits, taken from reg0[LED_W-1:0]
- clk  in  1  FCLK0, also MAXIGP0ACLK
- rst  in  1  synchronous, active-high
- ar_id / ar_addr / ar_len / ar_burst  in  12/32/4/2  read address channel
- ar_valid  in  1; ar_ready  out  1
- r_id  out  12; r_data  out  32; r_resp  out  2; r_last  out  1; r_valid  out  1; r_ready  in  1
- aw_id / aw_addr / aw_len / aw_burst  in  12/32/4/2  write address channel
- aw_valid  in  1; aw_ready  out  1
- w_data  in  32; w_strb  in  4; w_last  in  1; w_valid  in  1; w_ready  out  1 (WID is not used)
- b_id  out  12; b_resp  out  2; b_valid  out  1; b_ready  in  1
- led  out  LED_W  = reg0[LED_W-1:0]

## Operation
- States: IDLE, RD, WR, WRESP. Only one transaction is in flight at a time.
- IDLE ready signals are combinational:
  - ar_ready = ~rst & IDLE & ar_valid & (~aw_valid | prio==RD)
  - aw_ready = ~rst & IDLE & aw_valid & (~ar_valid | prio==WR)
- prio resets to RD. It toggles only when both valids are high in the same IDLE cycle.
- On an accepted address handshake, latch id, word offset = addr[11:2] (10 bits), len, burst, and beat counter = 0. Then go to RD or WR.
- Address stepping:
  - FIXED (00): offset held.
  - INCR (01) and WRAP (10, treated as INCR): offset+1 per beat, 10-bit wrap at 1023.
  - Reserved (11): treated as FIXED.
- A beat is in range when offset < NREGS. Address bits [31:12] are ignored.
- RD:
  - r_valid=1, r_id=latched id.
  - In range: r_data=reg[offset], r_resp=00. Out of range: r_data=0, r_resp=10 (SLVERR).
  - r_last = (beat==len).
  - On r_valid&r_ready: if last, go to IDLE; else beat+1 and step offset. Outputs hold while r_ready=0.
- WR:
  - w_ready=1. On w_valid&w_ready, in range: write byte lanes where w_strb[i]=1. Out of range: data dropped, sticky err set.
  - If w_last != (beat==len), set err. The beat count (len+1) alone ends the burst.
  - After the last beat, go to WRESP.
- WRESP: b_valid=1, b_id=latched id, b_resp = err ? 10 : 00. On b_ready, clear err and go to IDLE.
- Reset values:
  - reg0=32'h5555_5555, other regs 0.
  - All valid/ready outputs 0; r_data, r_id, b_id, r_resp, b_resp, r_last all 0.
  - State IDLE, prio RD, err 0.
- Reset mid-transaction: the transaction is dropped with no response, and any partially written burst keeps the beats already written. Registers return to reset values.

## Timing
- Read: AR handshake in cycle N, first r_valid in N+1, one beat per cycle with r_ready held high. The last beat handshake is in N+1+len.
- Write: AW handshake in N, w_ready from N+1, last W beat in cycle M, b_valid in M+1.
- A register write is visible to a read accepted in the cycle after the write's B handshake or later.
- led updates in the cycle after the W beat that writes reg0 byte 0.
- At least one IDLE cycle separates transactions. The next AR/AW is accepted no earlier than the cycle after the R-last or B handshake.
- ar_ready and aw_ready are never high in the same cycle.

## Test plan
- Reset, then single read addr 0x0, id 0x123: r_data=0x55555555, r_resp=00, r_last=1, r_id=0x123, r_valid one cycle after AR; led=4'b0101.
- Write addr 0x0, data 0x0000000A, strb 0001, id 0x7: reg0=0x5555550A, led=4'hA, b_resp=00, b_id=0x7, b_valid one cycle after W.
- INCR read, len=3 at addr 0x0 with r_ready toggling 1,0,1,0: 4 beats regs 0..3 in order, data stable while stalled, r_last only on beat 4.
- INCR write, len=5 at 0x8 (NREGS=4): regs 2,3 written, beats 3..6 dropped, b_resp=10. FIXED write len=1 at 0x4: reg1 holds the second beat, b_resp=00.
- ar_valid and aw_valid held together for 4 transactions: grant order read, write, read, write; ready never both high.
- rst pulsed during beat 2 of a len=3 read: r_valid=0 next cycle, reg0 back to 0x55555555, and a fresh read completes normally.
